// File: rtl/page_scheduler.sv
// Round-robin page dispatcher: hands 8-bit address pages to requesting cores and sums their results.
// Optional run-cycle counter on the `cycles` port when PAGE_SCHED_CYCLE_COUNT_EN is defined.
module page_scheduler #(
    parameter int CORES     = 16,
    parameter int PAGE_SIZE = 16,
    localparam int PAGES    = 256 / PAGE_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CORES-1:0] req,
    output logic [CORES-1:0] grant,
    output logic [7:0]       page_base,
    output logic [7:0]       page_limit,
    input  logic [CORES-1:0] res_valid,
    input  logic [8*CORES-1:0] res_data,
    output logic [15:0]      total,
    output logic             busy,
    output logic [1:0]       state_dbg,
    output logic             done
`ifdef PAGE_SCHED_CYCLE_COUNT_EN
    ,
    output logic [15:0]      cycles
`endif
);

    localparam int PTR_W = $clog2(CORES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Handshake: req is a level held by a core until it sees its one-cycle grant pulse;
    // res_valid is a one-cycle strobe honoured only while that core owns a page.
    state_t             state_q, state_d;
    logic [CORES-1:0]   req_q, req_d;
    logic [CORES-1:0]   pending_q, pending_d;
    logic [CORES-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [8:0]         next_page_q, next_page_d;
    logic [7:0]         page_base_q, page_base_d;
    logic [7:0]         page_limit_q, page_limit_d;
    logic [15:0]        total_q, total_d;
`ifdef PAGE_SCHED_CYCLE_COUNT_EN
    logic [15:0]        cycles_q, cycles_d;
`endif

    logic               active;
    logic [CORES-1:0]   accept;
    logic [CORES-1:0]   eligible;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W:0]     idx_w;

    always_comb begin
        state_d      = state_q;
        req_d        = req;
        pending_d    = pending_q;
        grant_d      = '0;
        ptr_d        = ptr_q;
        next_page_d  = next_page_q;
        page_base_d  = page_base_q;
        page_limit_d = page_limit_q;
        total_d      = total_q;
        accept       = '0;
        found        = 1'b0;
        win          = '0;
        idx_w        = '0;
        active       = (state_q == S_RUN) || (state_q == S_DRAIN);
`ifdef PAGE_SCHED_CYCLE_COUNT_EN
        cycles_d     = cycles_q;
        if (active && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end
`endif

        // Results retire before arbitration so a returning core waits one cycle for its next page.
        if (active) begin
            accept = res_valid & pending_q;
            for (int i = 0; i < CORES; i++) begin
                if (accept[i]) begin
                    total_d = total_d + 16'(res_data[8*i +: 8]);
                end
            end
            pending_d = pending_q & ~accept;
        end

        eligible = req_q & ~pending_q;
        for (int k = 0; k < CORES; k++) begin
            idx_w = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx_w >= (PTR_W+1)'(CORES)) begin
                idx_w = idx_w - (PTR_W+1)'(CORES);
            end
            if (!found && eligible[idx_w[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx_w[PTR_W-1:0];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    total_d     = '0;
                    next_page_d = '0;
                    pending_d   = '0;
                    ptr_d       = '0;
`ifdef PAGE_SCHED_CYCLE_COUNT_EN
                    cycles_d    = '0;
`endif
                end
            end
            S_RUN: begin
                if (found) begin
                    grant_d[win]   = 1'b1;
                    pending_d[win] = 1'b1;
                    ptr_d          = (win == PTR_W'(CORES-1)) ? '0 : win + 1'b1;
                    page_base_d    = 8'(32'(next_page_q) * PAGE_SIZE);
                    page_limit_d   = 8'(32'(next_page_q) * PAGE_SIZE) + 8'(PAGE_SIZE - 1);
                    next_page_d    = next_page_q + 9'd1;
                    if (next_page_q == 9'(PAGES - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pending_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            pending_q    <= '0;
            grant_q      <= '0;
            ptr_q        <= '0;
            next_page_q  <= '0;
            page_base_q  <= '0;
            page_limit_q <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            next_page_q  <= next_page_d;
            page_base_q  <= page_base_d;
            page_limit_q <= page_limit_d;
            total_q      <= total_d;
        end
    end

`ifdef PAGE_SCHED_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

    assign grant      = grant_q;
    assign page_base  = page_base_q;
    assign page_limit = page_limit_q;
    assign total      = total_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign state_dbg  = state_q;

endmodule

// File: doc/page_scheduler.md
# page_scheduler

Dynamic work scheduler for the multicore jimmy array. It splits the 8-bit data address space into fixed-size pages and hands one page at a time to whichever core asks, using a round-robin arbiter. It collects each core's 8-bit page result, such as a prime count, and keeps a running total. It flags completion once every page has been dispatched and answered, replacing the static one-page-per-core split and the bench-level result summing.

## Interface
Parameters:
- CORES, 16, number of requesting cores (2..16)
- PAGE_SIZE, 16, addresses per page; power of two, 1..256
- PAGES, 256/PAGE_SIZE, total pages per run (derived, do not override)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a run; sampled only in IDLE or DONE
- req  in  CORES  per-core page request level
- grant  out  CORES  one-hot, one-cycle pulse: the page on page_base/page_limit belongs to this core
- page_base  out  8  first address of granted page (in_port_0 of the core)
- page_limit  out  8  last address of granted page (in_port_3 of the core)
- res_valid  in  CORES  per-core one-cycle result strobe
- res_data  in  8*CORES  flattened results; core i on bits [8i+7:8i]
- total  out  16  accumulated sum of accepted results
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- cycles  out  16  run cycle count (only with macro, see Configuration)

## Operation
- State machine:
  - IDLE -> RUN on start: clears total, next_page, pending[] and the RR pointer (pointer = 0).
  - RUN: arbitrates requests. After the grant of page PAGES-1, go to DRAIN.
  - DRAIN: no grants; wait until pending[] == 0, then go to DONE.
  - DONE: done=1 and outputs held. start re-enters RUN with the same clears as from IDLE.
- start is ignored in RUN and DRAIN.
- Eligible cores: core i is eligible when req[i]=1 and pending[i]=0. A req from a pending core is ignored.
- Arbitration: round-robin. Search starts at the RR pointer; the first eligible core wins. After granting core i, the pointer becomes (i+1) mod CORES. At most one grant per cycle.
- On a grant to core i:
  - page_base = next_page*PAGE_SIZE
  - page_limit = page_base + PAGE_SIZE - 1
  - pending[i] is set and next_page increments.
  - page_base/page_limit hold their values until the next grant. The core latches them on the grant pulse.
- Results:
  - Every core i with res_valid[i]=1 and pending[i]=1 in RUN or DRAIN is accepted in that cycle. Several cores can be accepted in the same cycle.
  - Each accepted res_data byte is zero-extended and added to total, and pending[i] clears.
  - res_valid from a non-pending core is ignored, with no total change.
- Same-core grant and result in one cycle: the result is processed first, and the core can be granted again no earlier than the next cycle.
- total wraps modulo 2^16. The maximum legal sum (256 × 255 < 2^16) never wraps.
- Reset mid-run aborts the run with no residual state. Cores are not notified and are expected to be reset by the same reset.

## Timing
- Reset values: grant=0, page_base=0, page_limit=0, total=0, busy=0, done=0, cycles=0, state=IDLE.
- start sampled high at edge N: busy=1 after edge N.
- req sampled eligible at edge M: grant pulse and page fields are visible after edge M+1, for exactly one cycle.
- res_valid sampled at edge K: total is updated after edge K, and pending clears at edge K.
- DRAIN -> DONE: one edge after the last pending bit clears. done and busy=0 are visible after that edge.
- Dispatch throughput is at most one page per cycle, so PAGES grants take at least PAGES cycles.

## Configuration
- PAGE_SCHED_CYCLE_COUNT_EN defined:
  - cycles clears on start and increments every cycle in RUN and DRAIN.
  - It freezes in DONE and saturates at 16'hFFFF.
- Not defined: the cycles port is absent and no counter logic is built.

## Test plan
- Single core: core 0 requests continuously and replies res_data=1 two cycles after each grant.
  - Expect 16 grants with base 0,16,…,240 and limit 15,…,255.
  - Expect total=16 and done=1.
- All 16 req held high from the start edge: grants go to cores 0,1,…,15 on consecutive cycles, then DRAIN, with no second grant to any core.
- Cores 3,5,7,9 pulse res_valid in the same cycle with 1,2,3,4: total increases by exactly 10, and all four pending bits clear.
- Core 2 pulses res_valid=8'hFF while not pending: total unchanged, and no state change.
- Reset asserted mid-RUN after 5 grants: all outputs return to 0 immediately. A later start restarts with page_base=0 granted first.
- With PAGE_SCHED_CYCLE_COUNT_EN, one core, fixed 2-cycle reply: cycles equals the RUN+DRAIN cycle count (compare against the bench counter) and holds in DONE.
